multicycle_control_unit: RTL and testbench

//  Moore-FSM control unit for the multicycle MIPS datapath; successor to the single-cycle decoder.

---
 rtl/multicycle_control_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Moore-FSM control unit for the multicycle MIPS datapath.
//               Sequences FETCH/DECODE/EXECUTE/MEM/WB, stalls on memory
//               wait, flags illegal opcodes and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int OpCode_WIDTH     = 6,
    parameter int Funct_Width      = 6,
    parameter int ALUControl_WIDTH = 3,
    parameter int ALUOp_WIDTH      = 2,
    parameter bit ENABLE_BNE       = 1'b1,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [OpCode_WIDTH-1:0]     OpCode,
    input  logic [Funct_Width-1:0]      Funct,
    input  logic                        Zero_flag,
    input  logic                        Mem_Ready,
    output logic                        IorD,
    output logic                        IRWrite,
    output logic                        MemWrite,
    output logic                        MemtoReg,
    output logic                        RegDst,
    output logic                        RegWrite,
    output logic                        ALUSrcA,
    output logic [1:0]                  ALUSrcB,
    output logic [ALUControl_WIDTH-1:0] ALUControl,
    output logic [1:0]                  PCSrc,
    output logic                        PCEn,
    output logic                        Illegal_op,
    output logic [CNT_WIDTH-1:0]        Instr_Retired
);

    // Opcode / funct encodings
    localparam logic [OpCode_WIDTH-1:0] OP_RTYPE = OpCode_WIDTH'(6'b000000);
    localparam logic [OpCode_WIDTH-1:0] OP_LW    = OpCode_WIDTH'(6'b100011);
    localparam logic [OpCode_WIDTH-1:0] OP_SW    = OpCode_WIDTH'(6'b101011);
    localparam logic [OpCode_WIDTH-1:0] OP_ADDI  = OpCode_WIDTH'(6'b001000);
    localparam logic [OpCode_WIDTH-1:0] OP_BEQ   = OpCode_WIDTH'(6'b000100);
    localparam logic [OpCode_WIDTH-1:0] OP_BNE   = OpCode_WIDTH'(6'b000101);
    localparam logic [OpCode_WIDTH-1:0] OP_J     = OpCode_WIDTH'(6'b000010);

    localparam logic [Funct_Width-1:0] FN_ADD = Funct_Width'(6'b100000);
    localparam logic [Funct_Width-1:0] FN_SUB = Funct_Width'(6'b100010);
    localparam logic [Funct_Width-1:0] FN_SLT = Funct_Width'(6'b101010);
    localparam logic [Funct_Width-1:0] FN_MUL = Funct_Width'(6'b011100);

    localparam logic [ALUControl_WIDTH-1:0] ALU_ADD = ALUControl_WIDTH'(3'b010);
    localparam logic [ALUControl_WIDTH-1:0] ALU_SUB = ALUControl_WIDTH'(3'b100);
    localparam logic [ALUControl_WIDTH-1:0] ALU_SLT = ALUControl_WIDTH'(3'b110);
    localparam logic [ALUControl_WIDTH-1:0] ALU_MUL = ALUControl_WIDTH'(3'b101);

    localparam logic [ALUOp_WIDTH-1:0] ALUOP_ADD   = ALUOp_WIDTH'(2'b00);
    localparam logic [ALUOp_WIDTH-1:0] ALUOP_SUB   = ALUOp_WIDTH'(2'b01);
    localparam logic [ALUOp_WIDTH-1:0] ALUOP_FUNCT = ALUOp_WIDTH'(2'b10);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_ADDIEX  = 4'd8,
        S_ADDIWB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_WIDTH-1:0]   retired_q;
    logic [ALUOp_WIDTH-1:0] alu_op;
    logic                   is_bne;
    logic                   retire;

    // bne only exists as an instruction when the build enables it
    assign is_bne = ENABLE_BNE && (OpCode == OP_BNE);

    // State register; reset forces FETCH immediately so no strobe survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from current state, opcode and memory handshake
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = Mem_Ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((OpCode == OP_LW) || (OpCode == OP_SW)) begin
                    state_d = S_MEMADR;
                end else if (OpCode == OP_RTYPE) begin
                    state_d = S_EXECUTE;
                end else if (OpCode == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else if ((OpCode == OP_BEQ) || is_bne) begin
                    state_d = S_BRANCH;
                end else if (OpCode == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR:  state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = Mem_Ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = Mem_Ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode; Mem_Ready/Zero_flag/OpCode qualify a few strobes
    always_comb begin
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        PCEn       = 1'b0;
        Illegal_op = 1'b0;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = Mem_Ready;
                PCEn    = Mem_Ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                Illegal_op = !((OpCode == OP_LW) || (OpCode == OP_SW) ||
                               (OpCode == OP_RTYPE) || (OpCode == OP_ADDI) ||
                               (OpCode == OP_BEQ) || is_bne || (OpCode == OP_J));
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                PCEn    = ((OpCode == OP_BEQ) && Zero_flag) || (is_bne && !Zero_flag);
            end
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: begin
                ALUSrcB = 2'b00;
            end
        endcase
    end

    // ALU decoder: main-decoder code plus funct field to ALU operation
    always_comb begin
        ALUControl = ALU_ADD;
        if (alu_op == ALUOP_SUB) begin
            ALUControl = ALU_SUB;
        end else if (alu_op == ALUOP_FUNCT) begin
            case (Funct)
                FN_ADD:  ALUControl = ALU_ADD;
                FN_SUB:  ALUControl = ALU_SUB;
                FN_SLT:  ALUControl = ALU_SLT;
                FN_MUL:  ALUControl = ALU_MUL;
                default: ALUControl = ALU_ADD;
            endcase
        end
    end

    // An instruction retires on the final-state exit back to FETCH
    assign retire = (state_q == S_MEMWB)  || (state_q == S_ALUWB) ||
                    (state_q == S_ADDIWB) || (state_q == S_BRANCH) ||
                    (state_q == S_JUMP)   || ((state_q == S_MEMWR) && Mem_Ready);

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_WIDTH'(1);
        end
    end

    assign Instr_Retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Directed scoreboard bench for multicycle_control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXECUTE = 6, S_ALUWB = 7, S_ADDIEX = 8, S_ADDIWB = 9,
                   S_BRANCH = 10, S_JUMP = 11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OpCode, Funct;
    logic       Zero_flag, Mem_Ready;

    logic       a_IorD, a_IRWrite, a_MemWrite, a_MemtoReg, a_RegDst, a_RegWrite, a_ALUSrcA;
    logic [1:0] a_ALUSrcB, a_PCSrc;
    logic [2:0] a_ALUControl;
    logic       a_PCEn, a_Illegal;
    logic [3:0] a_cnt;

    logic       b_IorD, b_IRWrite, b_MemWrite, b_MemtoReg, b_RegDst, b_RegWrite, b_ALUSrcA;
    logic [1:0] b_ALUSrcB, b_PCSrc;
    logic [2:0] b_ALUControl;
    logic       b_PCEn, b_Illegal;
    logic [31:0] b_cnt;

    logic [15:0] a_cw, b_cw;
    assign a_cw = {a_IorD, a_IRWrite, a_MemWrite, a_MemtoReg, a_RegDst, a_RegWrite, a_ALUSrcA,
                   a_ALUSrcB, a_ALUControl, a_PCSrc, a_PCEn, a_Illegal};
    assign b_cw = {b_IorD, b_IRWrite, b_MemWrite, b_MemtoReg, b_RegDst, b_RegWrite, b_ALUSrcA,
                   b_ALUSrcB, b_ALUControl, b_PCSrc, b_PCEn, b_Illegal};

    multicycle_control_unit #(.ENABLE_BNE(1'b1), .CNT_WIDTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct),
        .Zero_flag(Zero_flag), .Mem_Ready(Mem_Ready),
        .IorD(a_IorD), .IRWrite(a_IRWrite), .MemWrite(a_MemWrite), .MemtoReg(a_MemtoReg),
        .RegDst(a_RegDst), .RegWrite(a_RegWrite), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
        .ALUControl(a_ALUControl), .PCSrc(a_PCSrc), .PCEn(a_PCEn), .Illegal_op(a_Illegal),
        .Instr_Retired(a_cnt)
    );

    multicycle_control_unit #(.ENABLE_BNE(1'b0)) u_nobne (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct),
        .Zero_flag(Zero_flag), .Mem_Ready(Mem_Ready),
        .IorD(b_IorD), .IRWrite(b_IRWrite), .MemWrite(b_MemWrite), .MemtoReg(b_MemtoReg),
        .RegDst(b_RegDst), .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
        .ALUControl(b_ALUControl), .PCSrc(b_PCSrc), .PCEn(b_PCEn), .Illegal_op(b_Illegal),
        .Instr_Retired(b_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          dut;
        logic [15:0] cw;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_cnt_a, exp_cnt_b;

    // Expected control word for a state, from the state-by-state output table
    function automatic logic [15:0] model_cw(int st, logic mr, logic z, logic [5:0] op,
                                             logic [5:0] fn, bit bne_en);
        logic iord, irw, mw, m2r, rd, rw, sa, pce, ill;
        logic [1:0] sb, pcs;
        logic [2:0] ac;
        bit legal;
        iord = 0; irw = 0; mw = 0; m2r = 0; rd = 0; rw = 0; sa = 0; pce = 0; ill = 0;
        sb = 2'b00; pcs = 2'b00; ac = 3'b010;
        case (st)
            S_FETCH:  begin sb = 2'b01; irw = mr; pce = mr; end
            S_DECODE: begin
                sb = 2'b11;
                legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
                        (op == 6'b001000) || (op == 6'b000100) || (op == 6'b000010) ||
                        (bne_en && op == 6'b000101);
                ill = !legal;
            end
            S_MEMADR: begin sa = 1; sb = 2'b10; end
            S_MEMRD:  iord = 1;
            S_MEMWB:  begin m2r = 1; rw = 1; end
            S_MEMWR:  begin iord = 1; mw = 1; end
            S_EXECUTE: begin
                sa = 1;
                case (fn)
                    6'b100010: ac = 3'b100;
                    6'b101010: ac = 3'b110;
                    6'b011100: ac = 3'b101;
                    default:   ac = 3'b010;
                endcase
            end
            S_ALUWB:  begin rd = 1; rw = 1; end
            S_ADDIEX: begin sa = 1; sb = 2'b10; end
            S_ADDIWB: rw = 1;
            S_BRANCH: begin
                sa = 1; ac = 3'b100; pcs = 2'b01;
                pce = ((op == 6'b000100) && z) || (bne_en && (op == 6'b000101) && !z);
            end
            S_JUMP:   begin pcs = 2'b10; pce = 1; end
            default:  ;
        endcase
        return {iord, irw, mw, m2r, rd, rw, sa, sb, ac, pcs, pce, ill};
    endfunction

    function automatic bit retires(int st, logic mr);
        return (st == S_MEMWB) || (st == S_ALUWB) || (st == S_ADDIWB) ||
               (st == S_BRANCH) || (st == S_JUMP) || ((st == S_MEMWR) && mr);
    endfunction

    // Push expected outputs for the currently driven stimulus (st_b < 0: skip second DUT)
    task automatic expect_state(input string tag, input int st_a, input int st_b);
        exp_t e;
        e.tag = tag; e.dut = 1'b0; e.cnt = exp_cnt_a;
        e.cw  = model_cw(st_a, Mem_Ready, Zero_flag, OpCode, Funct, 1'b1);
        sb_q.push_back(e);
        if (st_b >= 0) begin
            e.dut = 1'b1; e.cnt = exp_cnt_b;
            e.cw  = model_cw(st_b, Mem_Ready, Zero_flag, OpCode, Funct, 1'b0);
            sb_q.push_back(e);
        end
    endtask

    // Pop every pending expectation and compare against the DUT outputs
    task automatic compare_all();
        exp_t e;
        logic [15:0] obs_cw;
        logic [31:0] obs_cnt;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            obs_cw  = e.dut ? b_cw  : a_cw;
            obs_cnt = e.dut ? b_cnt : {28'd0, a_cnt};
            checks++;
            assert (obs_cw === e.cw) else begin
                errors++;
                $error("FAIL %s dut%0d ctrl observed=%h expected=%h", e.tag, e.dut, obs_cw, e.cw);
            end
            checks++;
            assert (obs_cnt === e.cnt) else begin
                errors++;
                $error("FAIL %s dut%0d count observed=%0d expected=%0d", e.tag, e.dut, obs_cnt, e.cnt);
            end
        end
    endtask

    // One clock cycle: expect, compare mid-cycle, advance models, next negedge
    task automatic cyc(input string tag, input int st_a, input int st_b);
        expect_state(tag, st_a, st_b);
        #1;
        compare_all();
        if (retires(st_a, Mem_Ready)) exp_cnt_a = (exp_cnt_a + 1) & 32'hF;
        if (st_b >= 0 && retires(st_b, Mem_Ready)) exp_cnt_b = exp_cnt_b + 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; Mem_Ready = 1'b0; Zero_flag = 1'b0;
        exp_cnt_a = 0; exp_cnt_b = 0;
        cyc("reset", S_FETCH, S_FETCH);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; OpCode = 6'b000000; Funct = 6'b100000;
        Zero_flag = 1'b0; Mem_Ready = 1'b0;
        exp_cnt_a = 0; exp_cnt_b = 0;
        @(negedge clk);
        do_reset();

        // lw with three wait cycles in FETCH and in MEMRD
        OpCode = 6'b100011;
        for (int i = 0; i < 3; i++) cyc("lw_fetch_wait", S_FETCH, -1);
        Mem_Ready = 1'b1; cyc("lw_fetch_rdy", S_FETCH, -1);
        Mem_Ready = 1'b0; cyc("lw_decode", S_DECODE, -1);
        cyc("lw_memadr", S_MEMADR, -1);
        for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", S_MEMRD, -1);
        Mem_Ready = 1'b1; cyc("lw_memrd_rdy", S_MEMRD, -1);
        Mem_Ready = 1'b0; cyc("lw_memwb", S_MEMWB, -1);
        cyc("lw_done", S_FETCH, -1);

        // beq taken and not taken
        OpCode = 6'b000100; Zero_flag = 1'b1;
        Mem_Ready = 1'b1; cyc("beqT_fetch", S_FETCH, -1);
        Mem_Ready = 1'b0; cyc("beqT_decode", S_DECODE, -1);
        cyc("beqT_branch", S_BRANCH, -1);
        Zero_flag = 1'b0;
        Mem_Ready = 1'b1; cyc("beqN_fetch", S_FETCH, -1);
        Mem_Ready = 1'b0; cyc("beqN_decode", S_DECODE, -1);
        cyc("beqN_branch", S_BRANCH, -1);

        // sw interrupted by reset while MemWrite is asserted
        OpCode = 6'b101011;
        Mem_Ready = 1'b1; cyc("sw_fetch", S_FETCH, -1);
        Mem_Ready = 1'b0; cyc("sw_decode", S_DECODE, -1);
        cyc("sw_memadr", S_MEMADR, -1);
        cyc("sw_memwr_wait", S_MEMWR, -1);
        expect_state("sw_memwr_hold", S_MEMWR, -1);
        #1; compare_all();
        rst_n = 1'b0; exp_cnt_a = 0;
        #1;
        expect_state("sw_async_reset", S_FETCH, -1);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // R-type slt then mul
        OpCode = 6'b000000; Funct = 6'b101010;
        Mem_Ready = 1'b1; cyc("slt_fetch", S_FETCH, -1);
        Mem_Ready = 1'b0; cyc("slt_decode", S_DECODE, -1);
        cyc("slt_execute", S_EXECUTE, -1);
        cyc("slt_aluwb", S_ALUWB, -1);
        Funct = 6'b011100;
        Mem_Ready = 1'b1; cyc("mul_fetch", S_FETCH, -1);
        Mem_Ready = 1'b0; cyc("mul_decode", S_DECODE, -1);
        cyc("mul_execute", S_EXECUTE, -1);
        cyc("mul_aluwb", S_ALUWB, -1);

        // addi
        OpCode = 6'b001000;
        Mem_Ready = 1'b1; cyc("addi_fetch", S_FETCH, -1);
        Mem_Ready = 1'b0; cyc("addi_decode", S_DECODE, -1);
        cyc("addi_ex", S_ADDIEX, -1);
        cyc("addi_wb", S_ADDIWB, -1);
        cyc("addi_done", S_FETCH, -1);

        // bne: illegal without ENABLE_BNE, taken branch with it
        do_reset();
        OpCode = 6'b000101; Zero_flag = 1'b0;
        Mem_Ready = 1'b1; cyc("bne_fetch", S_FETCH, S_FETCH);
        Mem_Ready = 1'b0; cyc("bne_decode", S_DECODE, S_DECODE);
        cyc("bne_branch", S_BRANCH, S_FETCH);
        cyc("bne_done", S_FETCH, S_FETCH);

        // sixteen back-to-back jumps wrap the 4-bit counter
        do_reset();
        OpCode = 6'b000010; Mem_Ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc("j_fetch", S_FETCH, -1);
            cyc("j_decode", S_DECODE, -1);
            cyc("j_jump", S_JUMP, -1);
        end
        Mem_Ready = 1'b0;
        cyc("j_wrapped", S_FETCH, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
